// File: rtl/pipealu_pkg.sv
// -----------------------------------------------------------------------------
// pipealu_pkg
// Shared definitions for the pipealu issue controller and its testbench:
//   - opcode constants and the NOP instruction word
//   - instruction field positions and field-extraction helpers
//   - issue FSM state enum and scoreboard entry type
// -----------------------------------------------------------------------------
package pipealu_pkg;

    // Opcodes
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_SLT = 4'h7;
    localparam logic [3:0] OP_NOR = 4'hC;
    localparam logic [3:0] OP_NOP = 4'hF;

    localparam logic [15:0] NOP_INSTR = 16'hf000;

    // Instruction field positions
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RS_MSB  = 11;
    localparam int unsigned RS_LSB  = 8;
    localparam int unsigned RT_MSB  = 7;
    localparam int unsigned RT_LSB  = 4;
    localparam int unsigned RD_MSB  = 3;
    localparam int unsigned RD_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } issue_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
    } sb_entry_t;

    function automatic logic [3:0] f_opc(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [3:0] f_rs(input logic [15:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [3:0] f_rt(input logic [15:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [3:0] f_rd(input logic [15:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

    // True for opcodes that read rs/rt and write rd.
    function automatic logic is_alu_op(input logic [3:0] opc);
        logic r;
        case (opc)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: r = 1'b1;
            default:                                       r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_nop_op(input logic [3:0] opc);
        return opc == OP_NOP;
    endfunction

endpackage

// File: rtl/pipealu_issue_fifo.sv
// -----------------------------------------------------------------------------
// pipealu_issue_fifo
// Synchronous FIFO buffering instructions ahead of the issue stage.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   clr_i    synchronous clear (empties the FIFO, wins over push/pop)
//   push_i   write data_i (ignored when full)
//   pop_i    drop the head entry (ignored when empty)
//   data_i   write data
//   head_o   oldest entry (valid when !empty_o)
//   full_o   no free entry
//   empty_o  no entry stored
// -----------------------------------------------------------------------------
module pipealu_issue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pipealu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// pipealu_issue_ctrl
// In-order issue controller in front of pipealu. Buffers instructions in a
// FIFO, blocks RAW hazards against an in-flight destination scoreboard by
// issuing NOP bubbles, sanitises illegal opcodes and supports a flush.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   in_valid   requester presents in_instr
//   in_instr   {opcode, rs, rt, rd}
//   in_ready   FIFO accepts this cycle
//   flush      discard queue and drain pipeline
//   alu_instr  registered instruction to pipealu
//   stall      registered; alu_instr is a hazard bubble
//   illegal    registered pulse; illegal opcode replaced by NOP
//   busy       FIFO non-empty or scoreboard slot valid
//   stall_cnt  saturating count of hazard-bubble cycles
// -----------------------------------------------------------------------------
module pipealu_issue_ctrl
    import pipealu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PIPE_DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic [15:0] alu_instr,
    output logic        stall,
    output logic        illegal,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    issue_state_e state_q, state_d;
    sb_entry_t    sb_q [PIPE_DEPTH];
    sb_entry_t    sb_new;

    logic [15:0] alu_instr_q, alu_instr_d;
    logic        stall_q, stall_d;
    logic        illegal_q, illegal_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [15:0] head;
    logic        head_legal, hazard, sb_any;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    assign in_ready  = !fifo_full && (state_q != ST_FLUSH) && !flush;
    assign fifo_push = in_valid && in_ready;

    pipealu_issue_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (in_instr),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Hazard detection against every valid in-flight destination
    // ------------------------------------------------------------------
    assign head_legal = is_alu_op(f_opc(head));

    always_comb begin
        hazard = 1'b0;
        sb_any = 1'b0;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            if (sb_q[i].valid) begin
                sb_any = 1'b1;
                if ((sb_q[i].rd == f_rs(head)) || (sb_q[i].rd == f_rt(head))) begin
                    hazard = 1'b1;
                end
            end
        end
        hazard = hazard && head_legal && !fifo_empty;
    end

    assign busy = !fifo_empty || sb_any;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (priority ordered)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_FLUSH;
        end else if (state_q == ST_FLUSH && sb_any) begin
            state_d = ST_FLUSH;
        end else if (fifo_empty) begin
            state_d = ST_IDLE;
        end else if (hazard) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_ISSUE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The registered outputs describe the state being
    // entered, so they are decoded from state_d.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_pop    = 1'b0;
        alu_instr_d = NOP_INSTR;
        stall_d     = 1'b0;
        illegal_d   = 1'b0;
        stall_cnt_d = stall_cnt_q;
        sb_new      = '0;
        case (state_d)
            ST_ISSUE: begin
                fifo_pop = 1'b1;
                if (head_legal) begin
                    alu_instr_d  = head;
                    sb_new.valid = 1'b1;
                    sb_new.rd    = f_rd(head);
                end else if (is_nop_op(f_opc(head))) begin
                    alu_instr_d = head;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            ST_STALL: begin
                stall_d = 1'b1;
                if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and scoreboard shift
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_instr_q <= NOP_INSTR;
            stall_q     <= 1'b0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            alu_instr_q <= alu_instr_d;
            stall_q     <= stall_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
            sb_q[0]     <= sb_new;
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    assign alu_instr = alu_instr_q;
    assign stall     = stall_q;
    assign illegal   = illegal_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipealu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipealu_issue_ctrl
// Directed testbench for pipealu_issue_ctrl with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pipealu_issue_ctrl;
    import pipealu_pkg::*;

    localparam int unsigned PIPE_DEPTH = 3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic [15:0] alu_instr;
    logic        stall;
    logic        illegal;
    logic        busy;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    pipealu_issue_ctrl #(
        .FIFO_DEPTH (4),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .alu_instr (alu_instr),
        .stall     (stall),
        .illegal   (illegal),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins);
        in_valid = v;
        in_instr = ins;
    endtask

    task automatic drain();
        drive(1'b0, NOP_INSTR);
        repeat (PIPE_DEPTH + 1) tick();
        chk("drain_busy", busy, 0);
        chk("drain_alu", alu_instr, NOP_INSTR);
    endtask

    logic [15:0] ind [5];

    initial begin
        ind = '{16'h0562, 16'h1345, 16'h2678, 16'h69ab, 16'h7cde};
        rst      = 1'b0;
        flush    = 1'b0;
        drive(1'b0, NOP_INSTR);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Reset values
        chk("rst_alu", alu_instr, 16'hf000);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_stall", stall, 0);
        chk("rst_illegal", illegal, 0);

        // Independent stream: one issue per clock, no stalls
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ind[i]);
            tick();
            if (i > 0) begin
                chk("ind_alu", alu_instr, ind[i-1]);
                chk("ind_stall", stall, 0);
            end
        end
        drive(1'b0, NOP_INSTR);
        tick();
        chk("ind_alu_last", alu_instr, 16'h7cde);
        chk("ind_cnt", stall_cnt, 0);
        drain();

        // RAW hazard: consumer 4 cycles after producer, 3 bubbles
        drive(1'b1, 16'h0562);
        tick();
        drive(1'b1, 16'h2248);
        tick();
        chk("raw_prod", alu_instr, 16'h0562);
        drive(1'b0, NOP_INSTR);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("raw_bubble", alu_instr, NOP_INSTR);
            chk("raw_stall", stall, 1);
        end
        tick();
        chk("raw_cons", alu_instr, 16'h2248);
        chk("raw_stall_end", stall, 0);
        chk("raw_cnt", stall_cnt, 3);
        drain();

        // Illegal opcode replaced by NOP, no scoreboard entry
        drive(1'b1, 16'h3123);
        tick();
        drive(1'b1, 16'h2134);
        tick();
        chk("ill_alu", alu_instr, NOP_INSTR);
        chk("ill_pulse", illegal, 1);
        chk("ill_stall", stall, 0);
        drive(1'b0, NOP_INSTR);
        tick();
        chk("ill_next", alu_instr, 16'h2134);
        chk("ill_pulse_end", illegal, 0);
        chk("ill_no_stall", stall, 0);
        drain();

        // Opcode F issues verbatim and creates no scoreboard entry
        drive(1'b1, 16'hf0a5);
        tick();
        drive(1'b1, 16'h2566);
        tick();
        chk("nop_alu", alu_instr, 16'hf0a5);
        drive(1'b0, NOP_INSTR);
        tick();
        chk("nop_next", alu_instr, 16'h2566);
        chk("nop_no_stall", stall, 0);
        chk("nop_cnt", stall_cnt, 3);
        drain();

        // Backpressure with a stalled head
        drive(1'b1, 16'h0562);
        tick();
        drive(1'b1, 16'h2248);
        tick();
        chk("bp_a", alu_instr, 16'h0562);
        drive(1'b1, 16'h1345);
        tick();
        chk("bp_stall1", stall, 1);
        chk("bp_ready1", in_ready, 1);
        drive(1'b1, 16'h6679);
        tick();
        chk("bp_stall2", stall, 1);
        drive(1'b1, 16'h7abc);
        tick();
        chk("bp_stall3", stall, 1);
        chk("bp_full", in_ready, 0);
        drive(1'b1, 16'hc0de);
        tick();
        chk("bp_b", alu_instr, 16'h2248);
        chk("bp_ready2", in_ready, 1);
        tick();
        chk("bp_c", alu_instr, 16'h1345);
        drive(1'b0, NOP_INSTR);
        tick();
        chk("bp_d", alu_instr, 16'h6679);
        tick();
        chk("bp_e", alu_instr, 16'h7abc);
        tick();
        chk("bp_f", alu_instr, 16'hc0de);
        chk("bp_f_stall", stall, 0);
        tick();
        chk("bp_no_dup", alu_instr, NOP_INSTR);
        chk("bp_cnt", stall_cnt, 6);
        drain();

        // Flush with three queued instructions
        drive(1'b1, 16'h0562);
        tick();
        drive(1'b1, 16'h2248);
        tick();
        chk("fl_a", alu_instr, 16'h0562);
        drive(1'b1, 16'h1345);
        tick();
        drive(1'b1, 16'h69ab);
        tick();
        chk("fl_busy_pre", busy, 1);
        chk("fl_stall_pre", stall, 1);
        flush = 1'b1;
        drive(1'b1, 16'h7cde);
        tick();
        flush = 1'b0;
        drive(1'b0, NOP_INSTR);
        chk("fl_alu", alu_instr, NOP_INSTR);
        chk("fl_stall", stall, 0);
        chk("fl_busy", busy, 0);
        chk("fl_ready", in_ready, 0);
        tick();
        chk("fl_alu2", alu_instr, NOP_INSTR);
        chk("fl_ready2", in_ready, 1);
        drive(1'b1, 16'h7cde);
        tick();
        drive(1'b0, NOP_INSTR);
        tick();
        chk("fl_after", alu_instr, 16'h7cde);
        chk("fl_after_stall", stall, 0);
        chk("fl_cnt", stall_cnt, 8);
        drain();

        // Reset asserted mid-stall
        drive(1'b1, 16'h0562);
        tick();
        drive(1'b1, 16'h2248);
        tick();
        drive(1'b0, NOP_INSTR);
        tick();
        chk("mr_stall_pre", stall, 1);
        chk("mr_cnt_pre", stall_cnt, 9);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_alu", alu_instr, 16'hf000);
        chk("mr_stall", stall, 0);
        chk("mr_illegal", illegal, 0);
        chk("mr_cnt", stall_cnt, 0);
        chk("mr_ready", in_ready, 1);
        chk("mr_busy", busy, 0);
        rst = 1'b1;
        repeat (2) tick();
        chk("mr_lost_alu", alu_instr, NOP_INSTR);
        chk("mr_lost_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipealu_issue_ctrl.md
# pipealu_issue_ctrl

In-order issue controller in front of `pipealu`. It buffers 16-bit instructions from one requester in a small FIFO and checks each head instruction against an in-flight destination scoreboard. It issues the instruction onto `pipealu.instr` only when no read-after-write hazard exists, and inserts NOP bubbles (16'hf000) otherwise. It also sanitises illegal opcodes, supports a synchronous flush, and keeps a stall counter for performance checks.

## Interface
- `FIFO_DEPTH`, 4: input buffer entries; power of two, at least 2.
- `PIPE_DEPTH`, 3: cycles an issued destination stays in flight before `pipealu` writes it back.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: requester presents `in_instr`.
- `in_instr`, in, 16: instruction; [15:12] opcode, [11:8] rs, [7:4] rt, [3:0] rd.
- `in_ready`, out, 1: FIFO accepts this cycle; a transfer occurs when `in_valid && in_ready`.
- `flush`, in, 1: single-cycle request to discard the queue and drain the pipeline.
- `alu_instr`, out, 16: registered; drives `pipealu.instr`.
- `stall`, out, 1: registered; the current `alu_instr` is a hazard bubble.
- `illegal`, out, 1: registered one-cycle pulse; an illegal opcode was dequeued and converted to a NOP.
- `busy`, out, 1: FIFO non-empty or any scoreboard slot valid.
- `stall_cnt`, out, 16: saturating count of hazard-bubble cycles.

## Operation
- **Legal opcodes:** 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, C NOR.
  - All legal opcodes read rs and rt and write rd.
  - Opcode F is a NOP: it is issued and creates no scoreboard entry.
  - Any other opcode is illegal: it is dequeued, 16'hf000 is issued in its place, `illegal` pulses, and no scoreboard entry is created.
- **Scoreboard:** `sb[0..PIPE_DEPTH-1]`, each entry {valid, rd[3:0]}.
  - Every edge: `sb[i] <= sb[i-1]`, and `sb[0]` <= the rd of the instruction issued this edge (valid only for legal opcodes).
  - The entry shifted out of `sb[PIPE_DEPTH-1]` is dropped.
- **Hazard:** the FIFO head is legal and its rs or rt equals rd in any valid `sb[i]`. There is no forwarding. WAW and WAR never stall, because issue is in order.
- **States:**
  - IDLE: FIFO empty; issue NOP.
  - ISSUE: head has no hazard; pop it and issue it.
  - STALL: head has a hazard; issue NOP, set `stall`, increment `stall_cnt`.
  - FLUSH: FIFO cleared; issue NOPs until all scoreboard slots are invalid, then go to IDLE.
- **Transitions:** evaluated each cycle in priority order.
  1. `flush` forces FLUSH.
  2. Otherwise, in FLUSH, remain until the scoreboard is empty.
  3. Otherwise, FIFO empty goes to IDLE.
  4. Otherwise, hazard goes to STALL.
  5. Otherwise, go to ISSUE.
- **`in_ready`:** `!full && state != FLUSH && !flush`.
  - A full FIFO never accepts, even with a simultaneous pop; there is no same-cycle pass-through.
  - A push into an empty FIFO is visible as the head on the next cycle.
- **`stall_cnt`:** saturates at 16'hffff. It is cleared only by reset, not by flush.

## Timing
- **Reset values:** `alu_instr`=16'hf000, `stall`=0, `illegal`=0, `stall_cnt`=0, state IDLE, FIFO empty, all scoreboard slots invalid. Therefore `in_ready`=1 and `busy`=0.
- **Mid-operation reset:** asserting reset mid-operation immediately returns all of the above. Queued instructions are lost.
- **Latency:** an instruction accepted at edge N appears on `alu_instr` at edge N+1 at the earliest.
- **Independent instructions:** back-to-back independent instructions issue on consecutive cycles at one per clock.
- **Dependent pair:** if producer P is on `alu_instr` from edge E, a dependent consumer appears at edge E+PIPE_DEPTH+1. Exactly PIPE_DEPTH NOP cycles with `stall`=1 lie between them.
- **Flush timing:** `flush` at edge N makes `alu_instr`=NOP from edge N+1 and empties the FIFO. `busy` falls PIPE_DEPTH cycles after the last legal issue.
- **Flush with input:** `flush` together with `in_valid` drops the input.
- **`illegal`:** coincides with the edge at which the replacement NOP appears.

## Structure
- **Shared package `pipealu_pkg`:**
  - Opcode constants (AND, OR, ADD, SUB, SLT, NOR, NOP).
  - `NOP_INSTR` = 16'hf000.
  - Instruction field positions.
  - The issue-state enum, shared with the bench.
- **Sub-module `pipealu_issue_fifo`:** parameterised synchronous FIFO with push/pop/full/empty/head and a clear input.
- **Top level:** scoreboard, hazard compare, FSM and counter live in the top.

## Test plan
- **Reset:** release reset with `in_valid`=0 -> `alu_instr`=16'hf000, `in_ready`=1, `busy`=0, `stall_cnt`=0.
- **Independent stream:** 16'h0562, 1345, 2678, 69ab, 7cde on consecutive cycles -> they issue on five consecutive cycles, `stall` never set.
- **RAW hazard:** 16'h0562 then 16'h2248 (reads R2) -> 16'h2248 appears 4 cycles after 16'h0562, 3 NOPs with `stall`=1, `stall_cnt`=3.
- **Illegal opcode:** 16'h3123 then 16'h2134 -> NOP with `illegal` pulse, then 16'h2134 the next cycle with no stall (no scoreboard entry for R3).
- **Backpressure and full FIFO:** a hazard-stalled head plus 5 pushes -> `in_ready`=0 after 4 entries, no entry lost or duplicated, and all entries issue in order.
- **Flush and mid-stall reset:** `flush` with 3 queued instructions -> NOPs only, `busy` falls after 3 cycles, next accepted instruction issues normally. Reset asserted mid-stall -> all reset values immediately.
